// File: rtl/miniscope_ctrl.sv
// Miniscope RAM controller: free-running write pointer plus a triggered look-back readout.
// Read data arrives one clock after the read address, so valid, last and done trail the FSM by one cycle.
module miniscope_ctrl #(
  parameter int RAM_ADRB = 11,
  parameter int MXTBIN   = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mini_write_en,
  input  logic [MXTBIN-1:0]   fifo_tbins_mini,
  input  logic [MXTBIN-1:0]   fifo_pretrig_mini,
  input  logic                mini_start,
  input  logic [1:0]          parity_err_mini,
  output logic                fifo_wen,
  output logic [RAM_ADRB-1:0] fifo_wadr_mini,
  output logic [RAM_ADRB-1:0] fifo_radr_mini,
  output logic                mini_busy,
  output logic                mini_rd_valid,
  output logic                mini_rd_last,
  output logic                mini_done,
  output logic                mini_perr,
  output logic                mini_ovf
);

  typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

  state_t              state, state_nxt;
  logic [MXTBIN-1:0]   cnt, cnt_nxt;
  logic [RAM_ADRB-1:0] radr_nxt;
  logic                accept;
  logic                accept_zero;
  logic                read_end;

  // FLUSH accepts a new start so a request landing on the done cycle is not lost.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    radr_nxt    = fifo_radr_mini;
    accept      = mini_start && (state != READ);
    accept_zero = accept && (fifo_tbins_mini == '0);
    read_end    = (state == READ) && (cnt == MXTBIN'(1));
    case (state)
      IDLE, FLUSH: begin
        state_nxt = IDLE;
        if (accept && !accept_zero) begin
          state_nxt = READ;
          cnt_nxt   = fifo_tbins_mini;
          radr_nxt  = fifo_wadr_mini - {{(RAM_ADRB-MXTBIN){1'b0}}, fifo_pretrig_mini};
        end
      end
      READ: begin
        radr_nxt = fifo_radr_mini + RAM_ADRB'(1);
        cnt_nxt  = cnt - MXTBIN'(1);
        if (read_end) state_nxt = FLUSH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      fifo_wen       <= 1'b0;
      fifo_wadr_mini <= '0;
      fifo_radr_mini <= '0;
      mini_rd_valid  <= 1'b0;
      mini_rd_last   <= 1'b0;
      mini_done      <= 1'b0;
      mini_perr      <= 1'b0;
      mini_ovf       <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      fifo_radr_mini <= radr_nxt;
      fifo_wen       <= mini_write_en;
      if (fifo_wen) fifo_wadr_mini <= fifo_wadr_mini + RAM_ADRB'(1);
      mini_rd_valid  <= (state == READ);
      mini_rd_last   <= read_end;
      mini_done      <= read_end || accept_zero;
      // A new readout starts with a clean parity flag even if the old last word was bad.
      if (accept) mini_perr <= 1'b0;
      else if (mini_rd_valid && (|parity_err_mini)) mini_perr <= 1'b1;
      if (mini_start && (state == READ)) mini_ovf <= 1'b1;
    end
  end

  assign mini_busy = (state != IDLE);

endmodule

// File: tb/tb_miniscope_ctrl.sv
// Directed bench for miniscope_ctrl: hand-computed addresses and strobe timing per readout cycle.
module tb_miniscope_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        mini_write_en;
  logic [4:0]  fifo_tbins_mini;
  logic [4:0]  fifo_pretrig_mini;
  logic        mini_start;
  logic [1:0]  parity_err_mini;
  logic        fifo_wen;
  logic [10:0] fifo_wadr_mini;
  logic [10:0] fifo_radr_mini;
  logic        mini_busy;
  logic        mini_rd_valid;
  logic        mini_rd_last;
  logic        mini_done;
  logic        mini_perr;
  logic        mini_ovf;

  int n_vec = 0;
  int n_err = 0;

  miniscope_ctrl #(.RAM_ADRB(11), .MXTBIN(5)) dut (
    .clock(clock), .reset(reset), .mini_write_en(mini_write_en),
    .fifo_tbins_mini(fifo_tbins_mini), .fifo_pretrig_mini(fifo_pretrig_mini),
    .mini_start(mini_start), .parity_err_mini(parity_err_mini),
    .fifo_wen(fifo_wen), .fifo_wadr_mini(fifo_wadr_mini), .fifo_radr_mini(fifo_radr_mini),
    .mini_busy(mini_busy), .mini_rd_valid(mini_rd_valid), .mini_rd_last(mini_rd_last),
    .mini_done(mini_done), .mini_perr(mini_perr), .mini_ovf(mini_ovf)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_rd(input logic [4:0] tb, input logic [4:0] pt);
    mini_start        = 1'b1;
    fifo_tbins_mini   = tb;
    fifo_pretrig_mini = pt;
    tick();
    mini_start        = 1'b0;
    fifo_tbins_mini   = 5'd31;
    fifo_pretrig_mini = 5'd17;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wen"},   32'(fifo_wen), 0);
    chk({tag, "_wadr"},  32'(fifo_wadr_mini), 0);
    chk({tag, "_radr"},  32'(fifo_radr_mini), 0);
    chk({tag, "_busy"},  32'(mini_busy), 0);
    chk({tag, "_valid"}, 32'(mini_rd_valid), 0);
    chk({tag, "_last"},  32'(mini_rd_last), 0);
    chk({tag, "_done"},  32'(mini_done), 0);
    chk({tag, "_perr"},  32'(mini_perr), 0);
    chk({tag, "_ovf"},   32'(mini_ovf), 0);
  endtask

  // Entered in the first READ cycle (k=1); READ spans k=1..n, FLUSH is k=n+1.
  task automatic follow(input logic [10:0] base, input int n, input int ign_k, input int par_k,
                        input bit restart, input logic [4:0] rtb, input logic [4:0] rpt);
    logic [10:0] ea;
    for (int k = 1; k <= n + 1; k++) begin
      ea = base + 11'(k - 1);
      chk("busy", 32'(mini_busy), 1);
      if (k <= n) chk("radr", 32'(fifo_radr_mini), 32'(ea));
      chk("valid", 32'(mini_rd_valid), 32'(k >= 2));
      chk("last",  32'(mini_rd_last),  32'(k == n + 1));
      chk("done",  32'(mini_done),     32'(k == n + 1));
      mini_start = 1'b0;
      if (k == ign_k) begin
        mini_start = 1'b1; fifo_tbins_mini = 5'd3; fifo_pretrig_mini = 5'd5;
      end else if (restart && k == n + 1) begin
        mini_start = 1'b1; fifo_tbins_mini = rtb; fifo_pretrig_mini = rpt;
      end
      parity_err_mini = (k == par_k) ? 2'b10 : 2'b00;
      tick();
    end
    mini_start      = 1'b0;
    parity_err_mini = 2'b00;
    if (!restart) begin
      chk("idle_busy",  32'(mini_busy), 0);
      chk("idle_valid", 32'(mini_rd_valid), 0);
      chk("idle_done",  32'(mini_done), 0);
    end
  endtask

  initial begin
    reset = 1'b1; mini_write_en = 1'b0; mini_start = 1'b0;
    fifo_tbins_mini = '0; fifo_pretrig_mini = '0; parity_err_mini = '0;
    tick(); tick();
    chk_all_zero("rst");
    reset = 1'b0;

    // W=10, pretrig=3, tbins=4 -> 7..10
    mini_write_en = 1'b1;
    tick();
    chk("wen_on", 32'(fifo_wen), 1);
    chk("wadr_first", 32'(fifo_wadr_mini), 0);
    repeat (9) tick();
    mini_write_en = 1'b0;
    tick();
    chk("wadr10", 32'(fifo_wadr_mini), 10);
    chk("wen_off", 32'(fifo_wen), 0);
    start_rd(5'd4, 5'd3);
    follow(11'd7, 4, 0, 0, 1'b0, 5'd0, 5'd0);
    chk("perr_clean", 32'(mini_perr), 0);

    // W=1, pretrig=4, tbins=5 -> wraps 2045..1
    reset = 1'b1; tick(); reset = 1'b0;
    mini_write_en = 1'b1; tick();
    mini_write_en = 1'b0; tick();
    chk("wadr1", 32'(fifo_wadr_mini), 1);
    start_rd(5'd5, 5'd4);
    follow(11'd2045, 5, 0, 0, 1'b0, 5'd0, 5'd0);
    chk("wadr_frozen", 32'(fifo_wadr_mini), 1);

    // tbins=0: done next cycle only
    start_rd(5'd0, 5'd2);
    chk("z_done",  32'(mini_done), 1);
    chk("z_busy",  32'(mini_busy), 0);
    chk("z_valid", 32'(mini_rd_valid), 0);
    tick();
    chk("z_done2", 32'(mini_done), 0);
    chk("z_busy2", 32'(mini_busy), 0);
    chk("ovf_pre", 32'(mini_ovf), 0);

    // ignored start at k=2, restart on the done cycle
    start_rd(5'd8, 5'd0);
    follow(11'd1, 8, 2, 0, 1'b1, 5'd2, 5'd0);
    chk("ovf_set", 32'(mini_ovf), 1);
    follow(11'd1, 2, 0, 0, 1'b0, 5'd0, 5'd0);
    chk("ovf_hold", 32'(mini_ovf), 1);

    // parity error on valid word 3 (k=4)
    start_rd(5'd4, 5'd0);
    follow(11'd1, 4, 0, 4, 1'b0, 5'd0, 5'd0);
    chk("perr_set", 32'(mini_perr), 1);
    repeat (3) tick();
    chk("perr_hold", 32'(mini_perr), 1);
    start_rd(5'd1, 5'd0);
    chk("perr_clr", 32'(mini_perr), 0);
    follow(11'd1, 1, 0, 0, 1'b0, 5'd0, 5'd0);

    // reset during READ
    start_rd(5'd8, 5'd0);
    tick(); tick();
    chk("pre_rst_busy", 32'(mini_busy), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk_all_zero("midrst");
    for (int i = 0; i < 12; i++) begin
      chk("no_done", 32'(mini_done), 0);
      tick();
    end
    start_rd(5'd3, 5'd2);
    follow(11'd2046, 3, 0, 0, 1'b0, 5'd0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
